// File: rtl/csrsr_nest.sv
// mstatus/sstatus register with a hardware {MPIE,MPP} nesting stack so that
// nested M-mode trap handlers can mret without software saving mstatus.
module csrsr_nest #(
  parameter int XLEN        = 64,
  parameter int STACK_DEPTH = 4,
  parameter int S_SUPPORTED = 1,
  parameter int U_SUPPORTED = 1,
  parameter int F_SUPPORTED = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             StallW,
  input  logic                             TrapM,
  input  logic [1:0]                       NextPrivilegeModeM,
  input  logic [1:0]                       PrivilegeModeW,
  input  logic                             mretM,
  input  logic                             sretM,
  input  logic                             WriteMSTATUSM,
  input  logic                             WriteSSTATUSM,
  input  logic                             FlushStackM,
  input  logic                             FRegWriteM,
  input  logic [XLEN-1:0]                  CSRWriteValM,
  output logic [XLEN-1:0]                  MSTATUS_REGW,
  output logic [XLEN-1:0]                  SSTATUS_REGW,
  output logic                             STATUS_MIE,
  output logic                             STATUS_SIE,
  output logic                             STATUS_MPIE,
  output logic                             STATUS_SPIE,
  output logic                             STATUS_SPP,
  output logic                             STATUS_MPRV,
  output logic [1:0]                       STATUS_MPP,
  output logic [1:0]                       STATUS_FS,
  output logic [$clog2(STACK_DEPTH+1)-1:0] NestDepth,
  output logic                             StackOverflow
);

  localparam int PW = $clog2(STACK_DEPTH);
  localparam int DW = $clog2(STACK_DEPTH+1);

  localparam logic [1:0]  SXL_VAL = (S_SUPPORTED != 0) ? 2'b10 : 2'b00;
  localparam logic [1:0]  UXL_VAL = (U_SUPPORTED != 0) ? 2'b10 : 2'b00;
  localparam logic [63:0] XL64    = {28'b0, SXL_VAL, UXL_VAL, 32'b0};
  localparam logic [XLEN-1:0] XL_BITS = (XLEN == 64) ? XLEN'(XL64) : '0;
  localparam logic [XLEN-1:0] SS_HIDE = XLEN'(32'h0002_1888);

  logic mie, sie, mpie, spie, spp, mprv;
  logic [1:0] mpp, fs;
  logic n_mie, n_sie, n_mpie, n_spie, n_spp, n_mprv;
  logic [1:0] n_mpp, n_fs;

  logic [2:0]    stack_mem [STACK_DEPTH];
  logic [PW-1:0] ptr, n_ptr, ptr_dec;
  logic [DW-1:0] depth, n_depth;
  logic          ovf, n_ovf;
  logic          push;
  logic [2:0]    pop_entry;
  logic          full;
  logic          unused_ok;

  // Upper write-data bits that map to no writable field are simply ignored.
  assign unused_ok = ^CSRWriteValM;

  function automatic logic mpp_legal(input logic [1:0] m);
    return (m == 2'b11) || (m == 2'b01 && S_SUPPORTED != 0) ||
           (m == 2'b00 && U_SUPPORTED != 0);
  endfunction

  assign ptr_dec   = ptr - PW'(1);
  assign pop_entry = stack_mem[ptr_dec];
  assign full      = (depth == DW'(STACK_DEPTH));

  // One event per cycle in fixed priority; unsupported fields are clamped last.
  always_comb begin
    n_mie   = mie;
    n_sie   = sie;
    n_mpie  = mpie;
    n_spie  = spie;
    n_spp   = spp;
    n_mprv  = mprv;
    n_mpp   = mpp;
    n_fs    = fs;
    n_ptr   = ptr;
    n_depth = depth;
    n_ovf   = ovf;
    push    = 1'b0;
    if (TrapM) begin
      if (NextPrivilegeModeM == 2'b11) begin
        push   = 1'b1;
        n_ptr  = ptr + PW'(1);
        n_mpie = mie;
        n_mie  = 1'b0;
        n_mpp  = PrivilegeModeW;
        if (full) n_ovf = 1'b1;
        else      n_depth = depth + DW'(1);
      end else if (NextPrivilegeModeM == 2'b01 && S_SUPPORTED != 0) begin
        n_spie = sie;
        n_sie  = 1'b0;
        n_spp  = PrivilegeModeW[0];
      end
    end else if (mretM) begin
      n_mie = mpie;
      if (mpp != 2'b11) n_mprv = 1'b0;
      if (depth != '0) begin
        n_mpie  = pop_entry[2];
        n_mpp   = pop_entry[1:0];
        n_ptr   = ptr_dec;
        n_depth = depth - DW'(1);
      end else begin
        n_mpie = 1'b1;
        n_mpp  = (U_SUPPORTED != 0) ? 2'b00 : 2'b11;
      end
    end else if (sretM) begin
      n_sie  = spie;
      n_spie = 1'b1;
      n_spp  = 1'b0;
      n_mprv = 1'b0;
    end else if (FlushStackM) begin
      n_depth = '0;
      n_ovf   = 1'b0;
    end else if (WriteMSTATUSM) begin
      n_mie  = CSRWriteValM[3];
      n_sie  = CSRWriteValM[1];
      n_mpie = CSRWriteValM[7];
      n_spie = CSRWriteValM[5];
      n_spp  = CSRWriteValM[8];
      n_mprv = CSRWriteValM[17];
      n_fs   = CSRWriteValM[14:13];
      if (mpp_legal(CSRWriteValM[12:11])) n_mpp = CSRWriteValM[12:11];
    end else if (WriteSSTATUSM) begin
      n_sie  = CSRWriteValM[1];
      n_spie = CSRWriteValM[5];
      n_spp  = CSRWriteValM[8];
      n_fs   = CSRWriteValM[14:13];
    end else if (FRegWriteM) begin
      n_fs = 2'b11;
    end
    if (S_SUPPORTED == 0) begin
      n_sie  = 1'b0;
      n_spie = 1'b0;
      n_spp  = 1'b0;
    end
    if (U_SUPPORTED == 0) n_mprv = 1'b0;
    if (F_SUPPORTED == 0) n_fs = 2'b00;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mie   <= 1'b0;
      sie   <= 1'b0;
      mpie  <= 1'b0;
      spie  <= 1'b0;
      spp   <= 1'b0;
      mprv  <= 1'b0;
      mpp   <= 2'b00;
      fs    <= 2'b00;
      ptr   <= '0;
      depth <= '0;
      ovf   <= 1'b0;
    end else if (!StallW) begin
      mie   <= n_mie;
      sie   <= n_sie;
      mpie  <= n_mpie;
      spie  <= n_spie;
      spp   <= n_spp;
      mprv  <= n_mprv;
      mpp   <= n_mpp;
      fs    <= n_fs;
      ptr   <= n_ptr;
      depth <= n_depth;
      ovf   <= n_ovf;
    end
  end

  // Stack contents need no reset; when full the pointer already addresses the oldest entry.
  always_ff @(posedge clk) begin
    if (!reset && !StallW && push) stack_mem[ptr] <= {mpie, mpp};
  end

  always_comb begin
    MSTATUS_REGW         = XL_BITS;
    MSTATUS_REGW[1]      = sie;
    MSTATUS_REGW[3]      = mie;
    MSTATUS_REGW[5]      = spie;
    MSTATUS_REGW[7]      = mpie;
    MSTATUS_REGW[8]      = spp;
    MSTATUS_REGW[12:11]  = mpp;
    MSTATUS_REGW[14:13]  = fs;
    MSTATUS_REGW[17]     = mprv;
    MSTATUS_REGW[XLEN-1] = (fs == 2'b11);
  end

  assign SSTATUS_REGW  = MSTATUS_REGW & ~SS_HIDE;
  assign STATUS_MIE    = mie;
  assign STATUS_SIE    = sie;
  assign STATUS_MPIE   = mpie;
  assign STATUS_SPIE   = spie;
  assign STATUS_SPP    = spp;
  assign STATUS_MPRV   = mprv;
  assign STATUS_MPP    = mpp;
  assign STATUS_FS     = fs;
  assign NestDepth     = depth;
  assign StackOverflow = ovf;

endmodule

// File: tb/tb_csrsr_nest.sv
// Bench for csrsr_nest: directed nesting scenarios plus random events, all
// checked against a queue-based model of the status register and trap stack.
module tb_csrsr_nest;

  localparam logic [9:0] E_RST   = 10'h001;
  localparam logic [9:0] E_STALL = 10'h002;
  localparam logic [9:0] E_TRAP  = 10'h004;
  localparam logic [9:0] E_MRET  = 10'h008;
  localparam logic [9:0] E_SRET  = 10'h010;
  localparam logic [9:0] E_FLUSH = 10'h020;
  localparam logic [9:0] E_WM    = 10'h040;
  localparam logic [9:0] E_WS    = 10'h080;
  localparam logic [9:0] E_FREG  = 10'h100;

  logic        clk = 1'b0;
  logic        reset, StallW, TrapM, mretM, sretM;
  logic        WriteMSTATUSM, WriteSSTATUSM, FlushStackM, FRegWriteM;
  logic [1:0]  NextPrivilegeModeM, PrivilegeModeW;
  logic [63:0] CSRWriteValM;
  logic [63:0] MSTATUS_REGW, SSTATUS_REGW, nf_mstatus, nf_sstatus;
  logic        STATUS_MIE, STATUS_SIE, STATUS_MPIE, STATUS_SPIE, STATUS_SPP, STATUS_MPRV;
  logic [1:0]  STATUS_MPP, STATUS_FS, nf_mpp, nf_fs;
  logic        nf_mie, nf_sie, nf_mpie, nf_spie, nf_spp, nf_mprv, nf_ovf;
  logic [2:0]  NestDepth, nf_depth;
  logic        StackOverflow;

  always #5 clk = ~clk;

  csrsr_nest dut (
    .clk(clk), .reset(reset), .StallW(StallW), .TrapM(TrapM),
    .NextPrivilegeModeM(NextPrivilegeModeM), .PrivilegeModeW(PrivilegeModeW),
    .mretM(mretM), .sretM(sretM), .WriteMSTATUSM(WriteMSTATUSM),
    .WriteSSTATUSM(WriteSSTATUSM), .FlushStackM(FlushStackM), .FRegWriteM(FRegWriteM),
    .CSRWriteValM(CSRWriteValM), .MSTATUS_REGW(MSTATUS_REGW), .SSTATUS_REGW(SSTATUS_REGW),
    .STATUS_MIE(STATUS_MIE), .STATUS_SIE(STATUS_SIE), .STATUS_MPIE(STATUS_MPIE),
    .STATUS_SPIE(STATUS_SPIE), .STATUS_SPP(STATUS_SPP), .STATUS_MPRV(STATUS_MPRV),
    .STATUS_MPP(STATUS_MPP), .STATUS_FS(STATUS_FS), .NestDepth(NestDepth),
    .StackOverflow(StackOverflow)
  );

  csrsr_nest #(.F_SUPPORTED(0)) dut_nof (
    .clk(clk), .reset(reset), .StallW(StallW), .TrapM(TrapM),
    .NextPrivilegeModeM(NextPrivilegeModeM), .PrivilegeModeW(PrivilegeModeW),
    .mretM(mretM), .sretM(sretM), .WriteMSTATUSM(WriteMSTATUSM),
    .WriteSSTATUSM(WriteSSTATUSM), .FlushStackM(FlushStackM), .FRegWriteM(FRegWriteM),
    .CSRWriteValM(CSRWriteValM), .MSTATUS_REGW(nf_mstatus), .SSTATUS_REGW(nf_sstatus),
    .STATUS_MIE(nf_mie), .STATUS_SIE(nf_sie), .STATUS_MPIE(nf_mpie),
    .STATUS_SPIE(nf_spie), .STATUS_SPP(nf_spp), .STATUS_MPRV(nf_mprv),
    .STATUS_MPP(nf_mpp), .STATUS_FS(nf_fs), .NestDepth(nf_depth),
    .StackOverflow(nf_ovf)
  );

  bit       m_mie, m_sie, m_mpie, m_spie, m_spp, m_mprv, m_ovf;
  bit [1:0] m_mpp, m_fs;
  bit [2:0] stk[$];
  int       errors = 0;
  int       checks = 0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mkStatus(input bit mie, sie, mpie, spie, spp, mprv,
                                           input bit [1:0] mpp, fs, input bit f_on);
    logic [63:0] r;
    bit [1:0] f;
    f = f_on ? fs : 2'b00;
    r = '0;
    r[35:34] = 2'b10;
    r[33:32] = 2'b10;
    r[1] = sie;  r[3] = mie;  r[5] = spie; r[7] = mpie; r[8] = spp;
    r[12:11] = mpp; r[14:13] = f; r[17] = mprv;
    r[63] = (f == 2'b11);
    return r;
  endfunction

  function automatic logic [63:0] curM();
    return mkStatus(m_mie, m_sie, m_mpie, m_spie, m_spp, m_mprv, m_mpp, m_fs, 1'b1);
  endfunction

  // Reference behaviour: the stack is a bounded list of saved {MPIE,MPP}, newest at the back.
  task automatic modelStep(input logic [9:0] ev, input logic [1:0] np, pm, input logic [63:0] v);
    bit [2:0] e;
    bit       new_mie;
    if (ev & E_RST) begin
      {m_mie, m_sie, m_mpie, m_spie, m_spp, m_mprv, m_ovf} = '0;
      m_mpp = 0; m_fs = 0; stk.delete();
    end else if (ev & E_STALL) begin
    end else if (ev & E_TRAP) begin
      if (np == 2'b11) begin
        stk.push_back({m_mpie, m_mpp});
        if (stk.size() > 4) begin
          void'(stk.pop_front());
          m_ovf = 1;
        end
        m_mpie = m_mie; m_mie = 0; m_mpp = pm;
      end else if (np == 2'b01) begin
        m_spie = m_sie; m_sie = 0; m_spp = pm[0];
      end
    end else if (ev & E_MRET) begin
      new_mie = m_mpie;
      if (m_mpp != 2'b11) m_mprv = 0;
      if (stk.size() > 0) begin
        e = stk.pop_back();
        m_mpie = e[2]; m_mpp = e[1:0];
      end else begin
        m_mpie = 1; m_mpp = 2'b00;
      end
      m_mie = new_mie;
    end else if (ev & E_SRET) begin
      m_sie = m_spie; m_spie = 1; m_spp = 0; m_mprv = 0;
    end else if (ev & E_FLUSH) begin
      stk.delete(); m_ovf = 0;
    end else if (ev & E_WM) begin
      m_mie = v[3]; m_sie = v[1]; m_mpie = v[7]; m_spie = v[5]; m_spp = v[8];
      m_mprv = v[17]; m_fs = v[14:13];
      if (v[12:11] != 2'b10) m_mpp = v[12:11];
    end else if (ev & E_WS) begin
      m_sie = v[1]; m_spie = v[5]; m_spp = v[8]; m_fs = v[14:13];
    end else if (ev & E_FREG) begin
      m_fs = 2'b11;
    end
  endtask

  task automatic checkAll();
    checkOutput("mstatus", MSTATUS_REGW, curM());
    checkOutput("sstatus", SSTATUS_REGW,
                mkStatus(1'b0, m_sie, 1'b0, m_spie, m_spp, 1'b0, 2'b00, m_fs, 1'b1));
    checkOutput("fields", {STATUS_MIE, STATUS_SIE, STATUS_MPIE, STATUS_SPIE, STATUS_SPP,
                           STATUS_MPRV, STATUS_MPP, STATUS_FS},
                {m_mie, m_sie, m_mpie, m_spie, m_spp, m_mprv, m_mpp, m_fs});
    checkOutput("depth", NestDepth, stk.size());
    checkOutput("overflow", StackOverflow, m_ovf);
    checkOutput("nof_mstatus", nf_mstatus,
                mkStatus(m_mie, m_sie, m_mpie, m_spie, m_spp, m_mprv, m_mpp, m_fs, 1'b0));
    checkOutput("nof_fs", nf_fs, 2'b00);
  endtask

  task automatic applyStimulus(input logic [9:0] ev, input logic [1:0] np, pm,
                               input logic [63:0] v);
    reset = ev[0]; StallW = ev[1]; TrapM = ev[2]; mretM = ev[3]; sretM = ev[4];
    FlushStackM = ev[5]; WriteMSTATUSM = ev[6]; WriteSSTATUSM = ev[7]; FRegWriteM = ev[8];
    NextPrivilegeModeM = np; PrivilegeModeW = pm; CSRWriteValM = v;
    @(posedge clk);
    modelStep(ev, np, pm, v);
    #1;
    checkAll();
  endtask

  initial begin
    logic [9:0] ev;
    logic [1:0] np, pm;
    int r;
    applyStimulus(E_RST, 2'b00, 2'b00, '0);
    applyStimulus(E_RST, 2'b00, 2'b00, '0);

    // Three nested M traps from U, S, M with MPIE picking up 1,0,1, then unwind.
    applyStimulus(E_WM, 0, 0, 64'h8);
    applyStimulus(E_TRAP, 2'b11, 2'b00, '0);
    applyStimulus(E_TRAP, 2'b11, 2'b01, '0);
    applyStimulus(E_WM, 0, 0, curM() | 64'h8);
    applyStimulus(E_TRAP, 2'b11, 2'b11, '0);
    checkOutput("nest_mpp", STATUS_MPP, 2'b11);
    for (int i = 0; i < 3; i++) applyStimulus(E_MRET, 0, 0, '0);
    checkOutput("nest_depth0", NestDepth, 3'd0);

    // Overflow: five pushes into four slots, then drain past empty and flush.
    for (int i = 0; i < 5; i++) applyStimulus(E_TRAP, 2'b11, 2'(i % 2), '0);
    checkOutput("full_depth", NestDepth, 3'd4);
    checkOutput("full_ovf", StackOverflow, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(E_MRET, 0, 0, '0);
    checkOutput("empty_mret_mpp", STATUS_MPP, 2'b00);
    checkOutput("empty_mret_mpie", STATUS_MPIE, 1'b1);
    applyStimulus(E_FLUSH, 0, 0, '0);
    checkOutput("flush_ovf", StackOverflow, 1'b0);

    // Trap beats mret; stall freezes a trap until released.
    applyStimulus(E_TRAP | E_MRET, 2'b11, 2'b01, '0);
    checkOutput("trap_mret_depth", NestDepth, 3'd1);
    applyStimulus(E_STALL | E_TRAP, 2'b11, 2'b00, '0);
    checkOutput("stall_depth", NestDepth, 3'd1);
    applyStimulus(E_TRAP, 2'b11, 2'b00, '0);
    checkOutput("unstall_depth", NestDepth, 3'd2);

    // WARL MPP, FS dirtying.
    applyStimulus(E_WM, 0, 0, 64'h0800);
    applyStimulus(E_WM, 0, 0, 64'h1000);
    checkOutput("warl_keep", STATUS_MPP, 2'b01);
    applyStimulus(E_WM, 0, 0, 64'h0000);
    checkOutput("warl_zero", STATUS_MPP, 2'b00);
    applyStimulus(E_WS, 0, 0, 64'h2000);
    applyStimulus(E_FREG, 0, 0, '0);
    checkOutput("sd_set", MSTATUS_REGW[63], 1'b1);
    checkOutput("nof_sd", nf_mstatus[63], 1'b0);

    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if      (r < 2)  ev = E_RST;
      else if (r < 8)  ev = E_STALL | E_TRAP;
      else if (r < 35) ev = E_TRAP;
      else if (r < 60) ev = E_MRET;
      else if (r < 66) ev = E_SRET;
      else if (r < 70) ev = E_FLUSH;
      else if (r < 78) ev = E_WM;
      else if (r < 84) ev = E_WS;
      else if (r < 90) ev = E_FREG;
      else if (r < 94) ev = E_TRAP | E_MRET | E_FREG;
      else             ev = 10'h000;
      case ($urandom_range(0, 3))
        0: np = 2'b00;
        1: np = 2'b01;
        default: np = 2'b11;
      endcase
      case ($urandom_range(0, 2))
        0: pm = 2'b00;
        1: pm = 2'b01;
        default: pm = 2'b11;
      endcase
      applyStimulus(ev, np, pm, {$urandom, $urandom});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/csrsr_nest.md
Name: csrsr_nest

Overview:
- Machine/supervisor status register (mstatus/sstatus) with a hardware trap-nesting stack.
- On each trap into M-mode, the prior MPIE/MPP pair is pushed onto a parametrised-depth circular stack. Each mret pops it back.
- This lets nested M-mode handlers resume correctly without software saving mstatus.
- Sits in the privileged unit beside the trap and CSR-write logic. It feeds interrupt-enable, privilege and FP-state fields to the rest of the core.

Parameters:
- XLEN, 64, register width (32 or 64).
- STACK_DEPTH, 4, number of nested {MPIE,MPP} entries held (power of two, >=2).
- S_SUPPORTED, 1, supervisor mode present.
- U_SUPPORTED, 1, user mode present.
- F_SUPPORTED, 1, floating point present.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- StallW  in  1  freezes all state when high
- TrapM  in  1  trap taken this cycle
- NextPrivilegeModeM  in  2  trap target mode (11=M, 01=S, 00=U)
- PrivilegeModeW  in  2  current privilege mode
- mretM  in  1  mret retiring
- sretM  in  1  sret retiring
- WriteMSTATUSM  in  1  CSR write to mstatus
- WriteSSTATUSM  in  1  CSR write to sstatus
- FlushStackM  in  1  CSR-initiated stack clear
- FRegWriteM  in  1  FP register write (marks FS dirty)
- CSRWriteValM  in  XLEN  CSR write data
- MSTATUS_REGW  out  XLEN  mstatus read value
- SSTATUS_REGW  out  XLEN  sstatus read value
- STATUS_MIE, STATUS_SIE, STATUS_MPIE, STATUS_SPIE, STATUS_SPP, STATUS_MPRV  out  1 each  status fields
- STATUS_MPP  out  2  status field
- STATUS_FS  out  2  status field
- NestDepth  out  $clog2(STACK_DEPTH+1)  valid stack entries
- StackOverflow  out  1  sticky: an entry was overwritten

Behaviour:
- Clock and reset: reset reset, synchronous, active-high; clock clk.
- Reset values:
  - All status bits 0, MPP=00, FS=00.
  - NestDepth=0, StackOverflow=0, stack pointer 0.
  - Stack contents are don't-care.
- StallW=1: nothing updates; outputs hold.
- Reset asserted during any event wins.
- Event priority, one event per non-stalled cycle: TrapM > mretM > sretM > FlushStackM > WriteMSTATUSM > WriteSSTATUSM > FRegWriteM.
- Trap to M (NextPrivilegeModeM=11):
  - Push {MPIE,MPP} at the top pointer.
  - Then MPIE<=MIE, MIE<=0, MPP<=PrivilegeModeW.
  - Not full: NestDepth+1.
  - Full (NestDepth==STACK_DEPTH): the oldest entry is overwritten (circular); NestDepth unchanged; StackOverflow<=1.
- Trap to S (S_SUPPORTED only): SPIE<=SIE, SIE<=0, SPP<=PrivilegeModeW[0]. Stack untouched.
- mret:
  - MIE<=MPIE.
  - If MPP!=11, MPRV<=0.
  - NestDepth>0: {MPIE,MPP}<=top entry, pointer decrements, NestDepth-1.
  - NestDepth==0: MPIE<=1, MPP<=U_SUPPORTED?00:11. No error flagged.
- sret: SIE<=SPIE, SPIE<=1, SPP<=0, MPRV<=0.
- FlushStackM: NestDepth<=0, StackOverflow<=0. Status bits unchanged.
- mstatus write:
  - Writes MIE[3], SIE[1], MPIE[7], SPIE[5], SPP[8], MPRV[17], FS[14:13].
  - Writes MPP[12:11] as WARL: 10 or an unsupported mode leaves MPP unchanged.
  - The stack is not modified.
  - S-only bits are forced 0 when !S_SUPPORTED; MPRV is forced 0 when !U_SUPPORTED.
- sstatus write: writes SIE, SPIE, SPP, FS only.
- FRegWriteM: FS<=11.
- FS reads 00 when !F_SUPPORTED.
- SD (bit XLEN-1) = (FS==11).
- Register layouts:
  - MSTATUS_REGW: fields at the standard bit positions; all others 0; RV64 SXL/UXL=10 when the mode is supported.
  - SSTATUS_REGW: masks MIE, MPIE, MPP, MPRV to 0.
- Timing: all outputs are registered; an update is visible the cycle after the event.

Test Plan:
- Three nested M traps from U, S, M (MPIE values 1,0,1), then three mrets -> MPP sequence restored 11,01,00; MPIE restored in reverse order; NestDepth 3,2,1,0.
- STACK_DEPTH=4, five M traps -> NestDepth=4, StackOverflow=1. Four mrets restore the four newest entries; a fifth mret gives MPP=00, MPIE=1. FlushStackM clears StackOverflow.
- TrapM and mretM in the same cycle -> trap applied only; NestDepth+1.
- StallW=1 with TrapM=1 -> no change. Deassert StallW with TrapM=1 -> push occurs exactly once.
- mstatus write with [12:11]=10 while MPP=01 -> MPP stays 01; the same write with 00 sets MPP=00; NestDepth unchanged.
- FS=01, FRegWriteM=1 -> FS=11 and SD=1 next cycle. With F_SUPPORTED=0 -> FS reads 00 and SD=0.
